wt_dcache_srrip_ctrl: RTL and testbench
=======================================

# wt_dcache_srrip_ctrl

Replacement-state controller for the write-through L1 dcache. It owns the per-set, per-way SRRIP re-reference prediction values (RRPVs) and applies promotions on read hits. It serves victim-way requests from the miss path, aging the set as needed, and raises the conflict flag that read controllers use to replay reads colliding with an in-flight victim search.

## Interface
Parameters:
- `NumWays`, default `DCACHE_SET_ASSOC`: associativity; the number of RRPV entries per set.
- `IdxWidth`, default `DCACHE_CL_IDX_WIDTH`: set index width; the array has 2^IdxWidth sets.
- `RrpvWidth`, default `RRPV_WIDTH` (=2): bits per RRPV; the maximum value is RRPV_MAX = 2^RrpvWidth-1.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low
- `flush_i`  in  1  one-cycle pulse; sets every RRPV to RRPV_MAX
- `hit_vld_i`  in  1  read hit to promote
- `hit_idx_i`  in  IdxWidth  set of the hit
- `hit_way_oh_i`  in  NumWays  one-hot way of the hit
- `rd_idx_i`  in  IdxWidth  set currently being read by a read controller
- `conflict_o`  out  1  rd_idx_i matches the set locked by a victim search
- `vict_req_i`  in  1  victim request; held until grant
- `vict_idx_i`  in  IdxWidth  set needing a victim
- `vict_vld_bits_i`  in  NumWays  valid bits of that set
- `vict_rrpv_ins_i`  in  RrpvWidth  insertion RRPV from the signature predictor
- `vict_gnt_o`  out  1  one-cycle grant; vict_way_oh_o is valid in this cycle
- `vict_way_oh_o`  out  NumWays  one-hot victim way
- `busy_o`  out  1  FSM is not in IDLE

## Operation
- **States:** IDLE, SCAN, AGE.
- **IDLE:** when vict_req_i=1, register vict_idx_i, vict_vld_bits_i and vict_rrpv_ins_i, then go to SCAN.
- **SCAN:**
  - If any registered valid bit is 0, the victim is the lowest-index invalid way.
  - Otherwise, the victim is the lowest-index way whose RRPV equals RRPV_MAX.
  - If a victim exists: assert vict_gnt_o, drive vict_way_oh_o, write vict_rrpv_ins_q into the victim's RRPV at the clock edge, and go to IDLE.
  - If no victim exists: go to AGE.
- **AGE:** increment every RRPV of the locked set by 1, saturating at RRPV_MAX, then go to SCAN. At most RRPV_MAX AGE visits occur per request.
- **Hit promotion:** when hit_vld_i=1, the RRPV at (hit_idx_i, hit_way_oh_i) becomes 0 at the next edge. This happens in any state, including for other sets while aging.
- **Hits to the locked set:** hit_vld_i to the locked set while busy_o=1 is ignored. Read controllers replay via conflict_o, so such hits do not occur legally.
- **Same-cycle collisions:**
  - Hit and victim write on the same (set, way): the victim write wins.
  - Hit and victim write on different ways of the same set: both are applied.
- **conflict_o** = busy_o & (rd_idx_i == locked idx). It is combinational; it goes to 0 in the cycle after the grant.
- **flush_i:** all RRPVs become RRPV_MAX at the next edge.
  - flush_i takes priority over hit and victim writes in the same cycle.
  - An in-progress request in AGE goes to SCAN, which then finds a victim immediately.
  - A request in SCAN completes normally, but its insertion write is dropped in favour of the flush.
- **Width rules:** saturating increment only; no wrap from RRPV_MAX to 0. An all-zero vict_vld_bits_i selects way 0.

## Timing
- **Reset values:** every RRPV = RRPV_MAX; state = IDLE; vict_gnt_o=0, vict_way_oh_o=0, conflict_o=0, busy_o=0. Reset mid-search discards the request with no grant.
- **Latency:** request accepted in cycle 0 (IDLE) → grant in cycle 1 + 2·(AGE visits). Best case is cycle 1. Worst case with RrpvWidth=2 is cycle 7.
- **Handshake:**
  - The requester holds vict_req_i and the inputs stable until it sees vict_gnt_o, and deasserts vict_req_i in the following cycle.
  - A new request can be accepted in the cycle after the grant.
  - vict_way_oh_o is 0 whenever vict_gnt_o=0.
- **Hit updates:** single-cycle, with no backpressure.

## Structure
- **Add to wt_cache_pkg:** RRPV_WIDTH; `rrpv_t` (logic [RRPV_WIDTH-1:0]); the state enum `srrip_state_e` (IDLE, SCAN, AGE).
- **Storage:** the RRPV array is flops, written through one write-enable-per-way path per cycle.
- **Sub-module:** common_cells `lzc` (trailing-zero mode), instantiated twice: once for first-invalid selection and once for first-RRPV_MAX selection.

## Test plan
All scenarios use NumWays=4 and RrpvWidth=2.
- **Invalid way first:** reset, then request set 5 with vld=4'b1011 and ins=2 → grant in cycle 1, way_oh=4'b0100, RRPV[5][2]=2.
- **Aging:** set 3 with all ways valid and RRPVs {0,0,0,0} → three AGE passes, grant in cycle 7, way_oh=4'b0001; afterwards RRPVs = {ins,3,3,3}.
- **Promotion, conflict and dropped hit:** hit promotion to set 3 way 1 while set 9 ages → RRPV[3][1]=0. rd_idx_i=9 → conflict_o=1 until the grant. A hit to set 9 during the search is ignored.
- **Victim wins collision:** same-cycle hit and grant write on set 2 way 0 with ins=2 → RRPV[2][0]=2.
- **Flush mid-search:** flush_i pulse while in AGE on set 7 → every RRPV=3, then SCAN grants way 0 of set 7.
- **Reset mid-search:** rst_ni low during AGE → no grant, busy_o=0, all RRPVs=3.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared write-through cache constants and types; this slice carries the SRRIP
// replacement-state definitions used by the dcache replacement controller.
package wt_cache_pkg;

    localparam int unsigned DCACHE_SET_ASSOC    = 4;
    localparam int unsigned DCACHE_CL_IDX_WIDTH = 4;
    localparam int unsigned RRPV_WIDTH          = 2;

    typedef logic [RRPV_WIDTH-1:0] rrpv_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        AGE  = 2'd2
    } srrip_state_e;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter; MODE=0 counts trailing zeros (index of lowest set bit).
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Walk from the far end so the bit closest to the counting origin wins.
    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[MODE ? (WIDTH - 1 - i) : i]) begin
                cnt_o   = CNT_WIDTH'(i);
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wt_dcache_srrip_ctrl.sv
// SRRIP replacement-state controller: holds per-set/way RRPVs, promotes on hits,
// and searches/ages a locked set to hand out victim ways to the miss path.
module wt_dcache_srrip_ctrl
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumWays   = DCACHE_SET_ASSOC,
    parameter int unsigned IdxWidth  = DCACHE_CL_IDX_WIDTH,
    parameter int unsigned RrpvWidth = RRPV_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 hit_vld_i,
    input  logic [IdxWidth-1:0]  hit_idx_i,
    input  logic [NumWays-1:0]   hit_way_oh_i,
    input  logic [IdxWidth-1:0]  rd_idx_i,
    output logic                 conflict_o,
    input  logic                 vict_req_i,
    input  logic [IdxWidth-1:0]  vict_idx_i,
    input  logic [NumWays-1:0]   vict_vld_bits_i,
    input  logic [RrpvWidth-1:0] vict_rrpv_ins_i,
    output logic                 vict_gnt_o,
    output logic [NumWays-1:0]   vict_way_oh_o,
    output logic                 busy_o
);

    localparam int unsigned NumSets  = 2 ** IdxWidth;
    localparam int unsigned WayIdxW  = (NumWays > 1) ? $clog2(NumWays) : 1;
    localparam logic [RrpvWidth-1:0] RrpvMax = '1;
    localparam logic [RrpvWidth-1:0] RrpvOne = 1;
    localparam logic [NumWays-1:0]   WayOne  = 1;

    srrip_state_e state_q, state_d;

    logic [IdxWidth-1:0]  idx_q;
    logic [NumWays-1:0]   vld_q;
    logic [RrpvWidth-1:0] ins_q;
    logic [RrpvWidth-1:0] rrpv_q [NumSets][NumWays];

    logic [NumWays-1:0]   inv_vec, max_vec;
    logic [WayIdxW-1:0]   inv_cnt, max_cnt, vict_sel;
    logic                 inv_empty, max_empty, vict_found;
    logic                 hit_drop;

    always_comb begin
        inv_vec = ~vld_q;
        max_vec = '0;
        for (int w = 0; w < NumWays; w++) begin
            max_vec[w] = (rrpv_q[idx_q][w] == RrpvMax);
        end
    end

    lzc #(.WIDTH(NumWays), .MODE(1'b0)) u_inv_lzc (
        .in_i    (inv_vec),
        .cnt_o   (inv_cnt),
        .empty_o (inv_empty)
    );

    lzc #(.WIDTH(NumWays), .MODE(1'b0)) u_max_lzc (
        .in_i    (max_vec),
        .cnt_o   (max_cnt),
        .empty_o (max_empty)
    );

    // Invalid ways always beat RRPV_MAX ways.
    assign vict_sel   = !inv_empty ? inv_cnt : max_cnt;
    assign vict_found = !inv_empty || !max_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (vict_req_i) state_d = SCAN;
            SCAN:    state_d = vict_found ? IDLE : AGE;
            AGE:     state_d = SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state_q != IDLE);
        vict_gnt_o    = (state_q == SCAN) && vict_found;
        vict_way_oh_o = vict_gnt_o ? (WayOne << vict_sel) : '0;
        conflict_o    = busy_o && (rd_idx_i == idx_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
            vld_q <= '0;
            ins_q <= '0;
        end else if ((state_q == IDLE) && vict_req_i) begin
            idx_q <= vict_idx_i;
            vld_q <= vict_vld_bits_i;
            ins_q <= vict_rrpv_ins_i;
        end
    end

    // Hits to the locked set are dropped, except in the granting cycle where the
    // victim write is applied after the hit so it wins on the same way.
    assign hit_drop = busy_o && (hit_idx_i == idx_q) && !vict_gnt_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    rrpv_q[s][w] <= RrpvMax;
                end
            end
        end else if (flush_i) begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    rrpv_q[s][w] <= RrpvMax;
                end
            end
        end else begin
            for (int w = 0; w < NumWays; w++) begin
                if (hit_vld_i && !hit_drop && hit_way_oh_i[w]) begin
                    rrpv_q[hit_idx_i][w] <= '0;
                end
                if (state_q == AGE && rrpv_q[idx_q][w] != RrpvMax) begin
                    rrpv_q[idx_q][w] <= rrpv_q[idx_q][w] + RrpvOne;
                end
                if (vict_gnt_o && (vict_sel == WayIdxW'(w))) begin
                    rrpv_q[idx_q][w] <= ins_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_wt_dcache_srrip_ctrl.sv
// Directed bench for the SRRIP replacement controller (4 ways, 2-bit RRPVs, 16 sets).
module tb_wt_dcache_srrip_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       hit_vld_i;
    logic [3:0] hit_idx_i;
    logic [3:0] hit_way_oh_i;
    logic [3:0] rd_idx_i;
    logic       conflict_o;
    logic       vict_req_i;
    logic [3:0] vict_idx_i;
    logic [3:0] vict_vld_bits_i;
    logic [1:0] vict_rrpv_ins_i;
    logic       vict_gnt_o;
    logic [3:0] vict_way_oh_o;
    logic       busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    wt_dcache_srrip_ctrl #(.NumWays(4), .IdxWidth(4), .RrpvWidth(2)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .hit_vld_i       (hit_vld_i),
        .hit_idx_i       (hit_idx_i),
        .hit_way_oh_i    (hit_way_oh_i),
        .rd_idx_i        (rd_idx_i),
        .conflict_o      (conflict_o),
        .vict_req_i      (vict_req_i),
        .vict_idx_i      (vict_idx_i),
        .vict_vld_bits_i (vict_vld_bits_i),
        .vict_rrpv_ins_i (vict_rrpv_ins_i),
        .vict_gnt_o      (vict_gnt_o),
        .vict_way_oh_o   (vict_way_oh_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive all four ways of a set to RRPV 0 through hits.
    task automatic zero_set(input logic [3:0] idx);
        for (int w = 0; w < 4; w++) begin
            hit_vld_i    = 1'b1;
            hit_idx_i    = idx;
            hit_way_oh_i = 4'(1 << w);
            @(posedge clk_i); #1;
        end
        hit_vld_i = 1'b0;
    endtask

    // One victim request; cycle 0 is the IDLE accept cycle. ev_kind: 0 none, 1 hit,
    // 2 flush, 3 reset. A second optional hit is given by h2_*.
    task automatic search(input logic [3:0] idx, input logic [3:0] vld, input logic [1:0] ins,
                          input int ev_cyc, input int ev_kind, input logic [3:0] ev_idx,
                          input logic [3:0] ev_oh, input int h2_cyc, input logic [3:0] h2_idx,
                          input logic [3:0] h2_oh, output int gcyc, output logic [3:0] gway,
                          output int ncf, output logic busy_ev);
        gcyc            = -1;
        gway            = '0;
        ncf             = 0;
        busy_ev         = 1'b1;
        vict_req_i      = 1'b1;
        vict_idx_i      = idx;
        vict_vld_bits_i = vld;
        vict_rrpv_ins_i = ins;
        rd_idx_i        = idx;
        for (int c = 0; c < 16; c++) begin
            if (c == ev_cyc && ev_kind == 1) begin
                hit_vld_i = 1'b1; hit_idx_i = ev_idx; hit_way_oh_i = ev_oh;
            end
            if (c == h2_cyc) begin
                hit_vld_i = 1'b1; hit_idx_i = h2_idx; hit_way_oh_i = h2_oh;
            end
            if (c == ev_cyc && ev_kind == 2) flush_i = 1'b1;
            if (c == ev_cyc && ev_kind == 3) rst_ni = 1'b0;
            @(negedge clk_i);
            if (conflict_o) ncf++;
            if (c == ev_cyc) busy_ev = busy_o;
            if (vict_gnt_o) begin
                gcyc = c;
                gway = vict_way_oh_o;
            end
            @(posedge clk_i); #1;
            hit_vld_i = 1'b0;
            flush_i   = 1'b0;
            if (c == ev_cyc && ev_kind == 3) begin
                rst_ni = 1'b1;
                break;
            end
            if (gcyc >= 0) break;
        end
        vict_req_i = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        @(negedge clk_i);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        n_checks++; if (vict_gnt_o !== 1'b0) $display("FAIL reset_gnt: got %b want 0", vict_gnt_o); else n_pass++;
        n_checks++; if (vict_way_oh_o !== 4'b0) $display("FAIL reset_way: got %b want 0000", vict_way_oh_o); else n_pass++;
        n_checks++; if (conflict_o !== 1'b0) $display("FAIL reset_conflict: got %b want 0", conflict_o); else n_pass++;
        bad = 0;
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++)
                if (dut.rrpv_q[s][w] !== 2'd3) bad++;
        n_checks++; if (bad != 0) $display("FAIL reset_rrpv: got %0d entries not 3 want 0", bad); else n_pass++;
        @(posedge clk_i); #1;
    endtask

    task automatic test_invalid_first();
        int gc, nc; logic [3:0] gw; logic be;
        search(4'd5, 4'b1011, 2'd2, -1, 0, 4'd0, 4'd0, -1, 4'd0, 4'd0, gc, gw, nc, be);
        n_checks++; if (gc != 1) $display("FAIL inv_cycle: got %0d want 1", gc); else n_pass++;
        n_checks++; if (gw !== 4'b0100) $display("FAIL inv_way: got %b want 0100", gw); else n_pass++;
        n_checks++; if (dut.rrpv_q[5][2] !== 2'd2) $display("FAIL inv_rrpv: got %0d want 2", dut.rrpv_q[5][2]); else n_pass++;
        search(4'd10, 4'b0000, 2'd2, -1, 0, 4'd0, 4'd0, -1, 4'd0, 4'd0, gc, gw, nc, be);
        n_checks++; if (gc != 1) $display("FAIL zero_vld_cycle: got %0d want 1", gc); else n_pass++;
        n_checks++; if (gw !== 4'b0001) $display("FAIL zero_vld_way: got %b want 0001", gw); else n_pass++;
    endtask

    task automatic test_aging();
        int gc, nc; logic [3:0] gw; logic be;
        zero_set(4'd3);
        search(4'd3, 4'b1111, 2'd1, -1, 0, 4'd0, 4'd0, -1, 4'd0, 4'd0, gc, gw, nc, be);
        n_checks++; if (gc != 7) $display("FAIL age_cycle: got %0d want 7", gc); else n_pass++;
        n_checks++; if (gw !== 4'b0001) $display("FAIL age_way: got %b want 0001", gw); else n_pass++;
        n_checks++; if (dut.rrpv_q[3][0] !== 2'd1) $display("FAIL age_rrpv0: got %0d want 1", dut.rrpv_q[3][0]); else n_pass++;
        n_checks++;
        if ({dut.rrpv_q[3][1], dut.rrpv_q[3][2], dut.rrpv_q[3][3]} !== 6'b111111)
            $display("FAIL age_rrpv123: got %0d %0d %0d want 3 3 3", dut.rrpv_q[3][1], dut.rrpv_q[3][2], dut.rrpv_q[3][3]);
        else n_pass++;
    endtask

    task automatic test_promo_conflict();
        int gc, nc; logic [3:0] gw; logic be;
        zero_set(4'd9);
        search(4'd9, 4'b1111, 2'd2, 2, 1, 4'd3, 4'b0010, 3, 4'd9, 4'b0100, gc, gw, nc, be);
        n_checks++; if (gc != 7) $display("FAIL promo_cycle: got %0d want 7", gc); else n_pass++;
        n_checks++; if (gw !== 4'b0001) $display("FAIL promo_way: got %b want 0001", gw); else n_pass++;
        n_checks++; if (nc != 7) $display("FAIL conflict_cycles: got %0d want 7", nc); else n_pass++;
        @(negedge clk_i);
        n_checks++; if (conflict_o !== 1'b0) $display("FAIL conflict_after_gnt: got %b want 0", conflict_o); else n_pass++;
        n_checks++; if (dut.rrpv_q[3][1] !== 2'd0) $display("FAIL promo_rrpv: got %0d want 0", dut.rrpv_q[3][1]); else n_pass++;
        n_checks++; if (dut.rrpv_q[9][2] !== 2'd3) $display("FAIL dropped_hit: got %0d want 3", dut.rrpv_q[9][2]); else n_pass++;
        n_checks++; if (dut.rrpv_q[9][0] !== 2'd2) $display("FAIL promo_ins: got %0d want 2", dut.rrpv_q[9][0]); else n_pass++;
        @(posedge clk_i); #1;
    endtask

    task automatic test_collision();
        int gc, nc; logic [3:0] gw; logic be;
        search(4'd2, 4'b1110, 2'd2, 1, 1, 4'd2, 4'b0001, -1, 4'd0, 4'd0, gc, gw, nc, be);
        n_checks++; if (gw !== 4'b0001) $display("FAIL coll_way: got %b want 0001", gw); else n_pass++;
        n_checks++; if (dut.rrpv_q[2][0] !== 2'd2) $display("FAIL coll_same_way: got %0d want 2", dut.rrpv_q[2][0]); else n_pass++;
        search(4'd4, 4'b1110, 2'd1, 1, 1, 4'd4, 4'b1000, -1, 4'd0, 4'd0, gc, gw, nc, be);
        n_checks++; if (dut.rrpv_q[4][0] !== 2'd1) $display("FAIL coll_vict: got %0d want 1", dut.rrpv_q[4][0]); else n_pass++;
        n_checks++; if (dut.rrpv_q[4][3] !== 2'd0) $display("FAIL coll_hit: got %0d want 0", dut.rrpv_q[4][3]); else n_pass++;
    endtask

    task automatic test_flush();
        int gc, nc; logic [3:0] gw; logic be;
        zero_set(4'd7);
        search(4'd7, 4'b1111, 2'd1, 2, 2, 4'd0, 4'd0, -1, 4'd0, 4'd0, gc, gw, nc, be);
        n_checks++; if (gc != 3) $display("FAIL flush_cycle: got %0d want 3", gc); else n_pass++;
        n_checks++; if (gw !== 4'b0001) $display("FAIL flush_way: got %b want 0001", gw); else n_pass++;
        n_checks++; if (dut.rrpv_q[7][0] !== 2'd1) $display("FAIL flush_ins: got %0d want 1", dut.rrpv_q[7][0]); else n_pass++;
        n_checks++; if (dut.rrpv_q[7][2] !== 2'd3) $display("FAIL flush_set7: got %0d want 3", dut.rrpv_q[7][2]); else n_pass++;
        n_checks++; if (dut.rrpv_q[3][1] !== 2'd3) $display("FAIL flush_other: got %0d want 3", dut.rrpv_q[3][1]); else n_pass++;
        search(4'd6, 4'b1110, 2'd0, 1, 2, 4'd0, 4'd0, -1, 4'd0, 4'd0, gc, gw, nc, be);
        n_checks++; if (gc != 1) $display("FAIL flush_scan_cycle: got %0d want 1", gc); else n_pass++;
        n_checks++; if (dut.rrpv_q[6][0] !== 2'd3) $display("FAIL flush_drop_ins: got %0d want 3", dut.rrpv_q[6][0]); else n_pass++;
    endtask

    task automatic test_reset_mid_search();
        int gc, nc, bad, late_gnt; logic [3:0] gw; logic be;
        zero_set(4'd8);
        search(4'd8, 4'b1111, 2'd1, 2, 3, 4'd0, 4'd0, -1, 4'd0, 4'd0, gc, gw, nc, be);
        n_checks++; if (be !== 1'b0) $display("FAIL rst_busy: got %b want 0", be); else n_pass++;
        late_gnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (vict_gnt_o || busy_o) late_gnt++;
        end
        n_checks++; if (gc != -1 || late_gnt != 0) $display("FAIL rst_no_gnt: got cycle %0d late %0d want -1 0", gc, late_gnt); else n_pass++;
        bad = 0;
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++)
                if (dut.rrpv_q[s][w] !== 2'd3) bad++;
        n_checks++; if (bad != 0) $display("FAIL rst_rrpv: got %0d entries not 3 want 0", bad); else n_pass++;
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; hit_vld_i = 1'b0; hit_idx_i = '0; hit_way_oh_i = '0;
        rd_idx_i = '0; vict_req_i = 1'b0; vict_idx_i = '0; vict_vld_bits_i = '0; vict_rrpv_ins_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        test_reset();
        test_invalid_first();
        test_aging();
        test_promo_conflict();
        test_collision();
        test_flush();
        test_reset_mid_search();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
